// File: rtl/add_seq_pkg.sv
// Shared constants and types for the sequential slice adder controller.
package add_seq_pkg;

  // Width of one adder slice; the shared adder works on this many bits.
  localparam int SLICE_W = 6;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Signed two's-complement overflow from operand MSBs and result MSB.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_seq_ctrl_adder.sv
// Team 6-bit unsigned adder without carry-in; one instance is shared
// across all slices by add_seq_ctrl.
module adder
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] X,
  input  logic [SLICE_W-1:0] Y,
  output logic [SLICE_W-1:0] S,
  output logic               cout
);

  assign {cout, S} = {1'b0, X} + {1'b0, Y};

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequential A+B controller: one 6-bit adder is time-multiplexed over
// NSLICE slices, LSB first. A carry into a slice is absorbed by an extra
// INC pass that adds 1 to the freshly written slice.
// Optional feature: define ADD_SEQ_OVF_EN to add the signed overflow
// output ovf.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter  int NSLICE = 4,
  localparam int W      = SLICE_W * NSLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] SUM,
  output logic         cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t state_q, state_d;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;          // working result, written slice by slice
  logic [W-1:0]  sum_out_q, sum_out_d;  // result presented on SUM
  logic [KW-1:0] k_q, k_d;
  logic          c_q, c_d;              // carry into the current slice
  logic          c1_q, c1_d;            // carry out of the ADD pass
  logic          cout_q, cout_d;
`ifdef ADD_SEQ_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] adder_x_s;
  logic [SLICE_W-1:0] adder_y_s;
  logic [SLICE_W-1:0] adder_s_s;
  logic               adder_co_s;
  logic               last_s;
  logic               slice_done_s;

  adder u_adder (
    .X    (adder_x_s),
    .Y    (adder_y_s),
    .S    (adder_s_s),
    .cout (adder_co_s)
  );

  assign last_s = (k_q == K_LAST);

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        if (c_q) begin
          state_d = INC;
        end else if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      INC: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; in_ready is held low during reset.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = ~rst;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Adder operand mux: operand slices in ADD, stored slice plus one in INC.
  always_comb begin
    if (state_q == INC) begin
      adder_x_s = sum_q[k_q*SLICE_W +: SLICE_W];
      adder_y_s = 6'b000001;
    end else begin
      adder_x_s = a_q[k_q*SLICE_W +: SLICE_W];
      adder_y_s = b_q[k_q*SLICE_W +: SLICE_W];
    end
  end

  // Datapath next-state: slice write-back, carry tracking, result capture.
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    sum_out_d    = sum_out_q;
    k_d          = k_q;
    c_d          = c_q;
    c1_d         = c1_q;
    cout_d       = cout_q;
    slice_done_s = 1'b0;
`ifdef ADD_SEQ_OVF_EN
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = A;
          b_d = B;
          k_d = {KW{1'b0}};
          c_d = 1'b0;
        end else begin
          a_d = a_q;
        end
      end
      ADD: begin
        sum_d[k_q*SLICE_W +: SLICE_W] = adder_s_s;
        c1_d = adder_co_s;
        if (c_q) begin
          slice_done_s = 1'b0;
        end else begin
          c_d          = adder_co_s;
          slice_done_s = 1'b1;
        end
      end
      INC: begin
        sum_d[k_q*SLICE_W +: SLICE_W] = adder_s_s;
        c_d          = c1_q | adder_co_s;
        slice_done_s = 1'b1;
      end
      DONE: begin
        sum_out_d = sum_out_q;
      end
      default: begin
        sum_out_d = sum_out_q;
      end
    endcase

    if (slice_done_s) begin
      k_d = k_q + KW'(1);
      if (last_s) begin
        sum_out_d = sum_d;
        cout_d    = c_d;
`ifdef ADD_SEQ_OVF_EN
        ovf_d     = signed_ovf(a_q[W-1], b_q[W-1], adder_s_s[SLICE_W-1]);
`endif
      end else begin
        cout_d = cout_q;
      end
    end else begin
      k_d = k_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= {W{1'b0}};
      b_q       <= {W{1'b0}};
      sum_q     <= {W{1'b0}};
      sum_out_q <= {W{1'b0}};
      k_q       <= {KW{1'b0}};
      c_q       <= 1'b0;
      c1_q      <= 1'b0;
      cout_q    <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      sum_out_q <= sum_out_d;
      k_q       <= k_d;
      c_q       <= c_d;
      c1_q      <= c1_d;
      cout_q    <= cout_d;
`ifdef ADD_SEQ_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign SUM  = sum_out_q;
  assign cout = cout_q;
`ifdef ADD_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed and random checks of add_seq_ctrl with NSLICE=4 (24-bit operands).
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] A;
  logic [23:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] SUM;
  logic        cout;
`ifdef ADD_SEQ_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  add_seq_ctrl #(.NSLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .SUM       (SUM),
    .cout      (cout)
`ifdef ADD_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer an operand pair, accept it and wait for out_valid; checks latency.
  task automatic launch(input string tag, input logic [23:0] a, input logic [23:0] b, input int exp_lat);
    int lat;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  // Take the result and check the controller is back in IDLE with SUM held.
  task automatic take(input string tag, input logic [23:0] exp_sum);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_sum_held"}, {8'd0, SUM}, {8'd0, exp_sum});
  endtask

  task automatic run_txn(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input int exp_lat, input logic [23:0] exp_sum, input logic exp_co,
                         input logic exp_ovf);
    launch(tag, a, b, exp_lat);
    check({tag, "_sum"}, {8'd0, SUM}, {8'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_co});
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
`ifdef ADD_SEQ_OVF_EN
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) begin
      check({tag, "_ovf_arg"}, {31'd0, exp_ovf}, 32'd0);
    end
`endif
    take(tag, exp_sum);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = 24'h000000;
    B         = 24'h000000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {8'd0, SUM}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    run_txn("basic",  24'h000123, 24'h000456, 4, 24'h000579, 1'b0, 1'b0);
    run_txn("ripple", 24'hFFFFFF, 24'h000001, 7, 24'h000000, 1'b1, 1'b0);
    run_txn("negneg", 24'h800000, 24'h800000, 4, 24'h000000, 1'b1, 1'b1);
    run_txn("posovf", 24'h7FFFFF, 24'h000001, 7, 24'h800000, 1'b0, 1'b1);
    run_txn("mixed",  24'hABCDEF, 24'h123456, 7, 24'hBE0245, 1'b0, 1'b0);
    run_txn("allone", 24'hFFFFFF, 24'hFFFFFF, 7, 24'hFFFFFE, 1'b1, 1'b0);

    // Consumer stall in DONE with stray in_valid pulses
    launch("stall", 24'h000123, 24'h000456, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      A        = 24'h111111 * (i + 1);
      B        = 24'h222222;
      @(posedge clk); #1;
      check("stall_ov", {31'd0, out_valid}, 32'd1);
      check("stall_sum", {8'd0, SUM}, 32'h000579);
      check("stall_cout", {31'd0, cout}, 32'd0);
      check("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    take("stall", 24'h000579);
    run_txn("after_stall", 24'h000001, 24'h000002, 4, 24'h000003, 1'b0, 1'b0);

    // Reset during the INC pass of slice 2
    check("pre_rst_ready", {31'd0, in_ready}, 32'd1);
    A        = 24'h03FFC0;
    B        = 24'h000040;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ov", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {8'd0, SUM}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", {31'd0, in_ready}, 32'd1);
    run_txn("fresh", 24'h00003F, 24'h000001, 5, 24'h000040, 1'b0, 1'b0);

    // Random back-to-back transactions with random out_ready
    for (int i = 0; i < 1000; i++) begin
      logic [23:0] ra;
      logic [23:0] rb;
      logic [24:0] ref_sum;
      int          guard;
      ra      = 24'($urandom);
      rb      = 24'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb};
      A        = ra;
      B        = rb;
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      check("rnd_accept", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      guard     = 0;
      while (!(out_valid && out_ready) && guard < 200) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        guard++;
      end
      check("rnd_sum", {8'd0, SUM}, {8'd0, ref_sum[23:0]});
      check("rnd_cout", {31'd0, cout}, {31'd0, ref_sum[24]});
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("rnd_single", {31'd0, out_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
